// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: FSM encoding, special instruction words and opcodes
// used by both the fetch stage and the branch_sum side of the pipeline.
package if_stage_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;

    // Opcodes resolved by branch_sum in ID
    localparam logic [5:0]  OP_BEQ  = 6'b000100;
    localparam logic [5:0]  OP_BNE  = 6'b000101;
    localparam logic [5:0]  OP_JUMP = 6'b000010;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: program counter, IF/ID pipeline register and the
// IDLE/RUN/HALT fetch FSM.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned PC_WIDE = 7,
    parameter logic [5:0]  HALT_OP = HALT_OPCODE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    input  logic               taken,
    input  logic [PC_WIDE-1:0] branch_pc,
    input  logic [31:0]        imem_data,
    output logic [PC_WIDE-1:0] pc,
    output logic [31:0]        id_instr,
    output logic [PC_WIDE-1:0] id_pc_next,
    output logic               id_valid,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_state_e       state;
    logic [PC_WIDE-1:0] pc_inc;
    logic               is_halt_word;
    logic [15:0]        count_inc;

    // Wraps naturally at the PC width
    assign pc_inc       = pc + {{(PC_WIDE-1){1'b0}}, 1'b1};
    assign is_halt_word = (opcode_of(imem_data) == HALT_OP);
    assign count_inc    = (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            pc          <= '0;
            id_instr    <= NOP_INSTR;
            id_pc_next  <= '0;
            id_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    id_instr   <= NOP_INSTR;
                    id_pc_next <= '0;
                    id_valid   <= 1'b0;
                    if (start) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (stall) begin
                        // Full hold; a redirect in the same cycle is dropped
                        state <= StRun;
                    end else if (taken) begin
                        pc         <= branch_pc;
                        id_instr   <= NOP_INSTR;
                        id_pc_next <= '0;
                        id_valid   <= 1'b0;
                    end else begin
                        id_instr    <= imem_data;
                        id_pc_next  <= pc_inc;
                        id_valid    <= 1'b1;
                        fetch_count <= count_inc;
                        if (is_halt_word) begin
                            state  <= StHalt;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                StHalt: begin
                    id_instr   <= NOP_INSTR;
                    id_pc_next <= '0;
                    id_valid   <= 1'b0;
                    halted     <= 1'b1;
                end
                default: begin
                    state      <= StIdle;
                    id_instr   <= NOP_INSTR;
                    id_pc_next <= '0;
                    id_valid   <= 1'b0;
                    halted     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage against an abstract fetch model.
module tb_if_stage;

    localparam int unsigned PW    = 7;
    localparam int unsigned DEPTH = 1 << PW;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stall;
    logic          taken;
    logic [PW-1:0] branch_pc;
    logic [31:0]   imem_data;
    logic [PW-1:0] pc;
    logic [31:0]   id_instr;
    logic [PW-1:0] id_pc_next;
    logic          id_valid;
    logic          halted;
    logic [15:0]   fetch_count;

    logic [31:0] mem [DEPTH];

    int checks;
    int errors;

    // Abstract model: running/halted flags, integer pc and count
    bit          m_run;
    bit          m_halt;
    int          m_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    int          m_pcn;
    int          m_cnt;

    if_stage #(
        .PC_WIDE(PW),
        .HALT_OP(6'b111111)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .taken      (taken),
        .branch_pc  (branch_pc),
        .imem_data  (imem_data),
        .pc         (pc),
        .id_instr   (id_instr),
        .id_pc_next (id_pc_next),
        .id_valid   (id_valid),
        .halted     (halted),
        .fetch_count(fetch_count)
    );

    assign imem_data = mem[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_halt  = 1'b0;
        m_pc    = 0;
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_pcn   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_pcn   = 0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        w = mem[m_pc];
        if (m_halt) begin
            model_bubble();
        end else if (!m_run) begin
            model_bubble();
            if (start) m_run = 1'b1;
        end else if (stall) begin
            // nothing moves
        end else if (taken) begin
            m_pc = int'(branch_pc);
            model_bubble();
        end else begin
            m_instr = w;
            m_valid = 1'b1;
            m_pcn   = (m_pc + 1) % DEPTH;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (w[31:26] == 6'b111111) begin
                m_run  = 1'b0;
                m_halt = 1'b1;
            end else begin
                m_pc = (m_pc + 1) % DEPTH;
            end
        end
    endtask

    task automatic compare_all();
        check("pc", 32'(pc), 32'(m_pc));
        check("id_valid", 32'(id_valid), 32'(m_valid));
        check("id_instr", id_instr, m_instr);
        check("halted", 32'(halted), 32'(m_halt));
        check("fetch_count", 32'(fetch_count), 32'(m_cnt));
        if (m_valid) check("id_pc_next", 32'(id_pc_next), 32'(m_pcn));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic s, input logic st, input logic tk, input int bpc);
        start     = s;
        stall     = st;
        taken     = tk;
        branch_pc = PW'(bpc);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without a clock
    task automatic pulse_reset();
        #1 rst = 1'b0;
        #1;
        model_reset();
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_pcn", 32'(id_pc_next), 32'h0);
        check("rst_valid", 32'(id_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_count", 32'(fetch_count), 32'h0);
        #1 rst = 1'b1;
    endtask

    task automatic fill_tagged();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + 32'(i);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 0);
        fill_tagged();
        model_reset();

        @(negedge clk);
        pulse_reset();

        // Startup and sequential fetch up to pc=5
        drive(1'b1, 1'b0, 1'b0, 0);
        cycle();
        check("idle_first", 32'(id_valid), 32'h0);
        cycle();
        check("first_word", id_instr, 32'h1000_0000);
        check("first_cnt", 32'(fetch_count), 32'd1);
        cycle();
        check("second_word", id_instr, 32'h1000_0001);
        check("second_cnt", 32'(fetch_count), 32'd2);
        repeat (3) cycle();
        check("pc_at5", 32'(pc), 32'd5);

        // Two-cycle stall
        drive(1'b0, 1'b1, 1'b0, 0);
        repeat (2) cycle();
        check("stall_pc", 32'(pc), 32'd5);
        drive(1'b0, 1'b0, 1'b0, 0);
        cycle();
        check("resume_word", id_instr, 32'h1000_0005);
        repeat (3) cycle();
        check("pc_at9", 32'(pc), 32'd9);

        // Redirect to 40
        drive(1'b0, 1'b0, 1'b1, 40);
        cycle();
        check("br_pc", 32'(pc), 32'd40);
        check("br_flush_pcn", 32'(id_pc_next), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 0);
        cycle();
        check("br_word", id_instr, 32'h1000_0028);
        check("br_pcn", 32'(id_pc_next), 32'd41);
        cycle();

        // Stall wins over taken, then taken alone redirects to the top address
        drive(1'b0, 1'b1, 1'b1, 127);
        cycle();
        check("stall_taken_pc", 32'(pc), 32'd42);
        drive(1'b0, 1'b0, 1'b1, 127);
        cycle();
        check("taken_pc", 32'(pc), 32'd127);

        // Wrap at 127, then halt word at address 3
        mem[3] = 32'hFC00_0003;
        drive(1'b0, 1'b0, 1'b0, 0);
        cycle();
        check("wrap_pcn", 32'(id_pc_next), 32'h0);
        check("wrap_pc", 32'(pc), 32'h0);
        repeat (4) cycle();
        check("halt_word", id_instr, 32'hFC00_0003);
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_pc", 32'(pc), 32'd3);
        drive(1'b1, 1'b0, 1'b0, 0);
        repeat (3) cycle();
        check("halt_hold_pc", 32'(pc), 32'd3);
        mem[3] = 32'h1000_0003;

        // Reset in the middle of a run at pc=20
        pulse_reset();
        drive(1'b1, 1'b0, 1'b0, 0);
        repeat (21) cycle();
        check("pc_at20", 32'(pc), 32'd20);
        drive(1'b0, 1'b0, 1'b0, 0);
        pulse_reset();
        repeat (4) cycle();
        check("idle_after_rst", 32'(pc), 32'h0);

        // Randomized traffic with occasional halt words and resets
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom();
            if (mem[i][31:26] == 6'b111111) mem[i][31] = 1'b0;
            if ($urandom_range(15) == 0) mem[i][31:26] = 6'b111111;
        end
        for (int n = 0; n < 4000; n++) begin
            drive(1'($urandom_range(1)), 1'($urandom_range(3) == 0),
                  1'($urandom_range(5) == 0), int'($urandom_range(DEPTH - 1)));
            if (m_halt && $urandom_range(3) == 0) pulse_reset();
            else if ($urandom_range(300) == 0) pulse_reset();
            cycle();
        end

        // Long straight-line run to reach the count ceiling
        fill_tagged();
        pulse_reset();
        drive(1'b1, 1'b0, 1'b0, 0);
        for (int n = 0; n < 65540; n++) cycle();
        check("count_sat", 32'(fetch_count), 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter PC_WIDE, default 7: width of the word-indexed program counter.
REQ-002 SHALL have parameter HALT_OP, default 6'b111111: opcode that stops fetching.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1: level; begins fetching from IDLE.
REQ-006 SHALL have port stall  input  1: hazard hold of PC and IF/ID register.
REQ-007 SHALL have port taken  input  1: branch/jump resolved in ID by branch_sum.
REQ-008 SHALL have port branch_pc  input  PC_WIDE: redirect target from branch_sum.
REQ-009 SHALL have port imem_data  input  32: instruction memory combinational read at pc.
REQ-010 SHALL have port pc  output  PC_WIDE: fetch address to instruction memory.
REQ-011 SHALL have port id_instr  output  32: IF/ID registered instruction.
REQ-012 SHALL have port id_pc_next  output  PC_WIDE: IF/ID registered fetch address + 1, feeds branch_sum pc_next.
REQ-013 SHALL have port id_valid  output  1: id_instr is a real instruction, not a bubble.
REQ-014 SHALL have port halted  output  1: FSM is in HALT.
REQ-015 SHALL have port fetch_count  output  16: number of instructions latched with id_valid=1.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, HALT; IDLE->RUN when start=1; RUN->HALT as in REQ-022; HALT is left only by reset.
REQ-017 In IDLE and HALT, pc SHALL hold and IF/ID SHALL load a bubble (id_instr=0, id_valid=0); fetch_count SHALL hold.
REQ-018 In RUN, each cycle SHALL follow the priority stall > taken > normal fetch.
REQ-019 stall=1: pc, id_instr, id_pc_next, id_valid, fetch_count SHALL all hold; taken SHALL be ignored that cycle.
REQ-020 taken=1 with stall=0: pc SHALL load branch_pc; IF/ID SHALL load a bubble (flush), id_pc_next=0; fetch_count SHALL hold.
REQ-021 Normal fetch: id_instr<=imem_data, id_pc_next<=pc+1, id_valid<=1, pc<=pc+1, fetch_count<=fetch_count+1.
REQ-022 When a normal fetch latches an instruction with imem_data[31:26]==HALT_OP, the halt word SHALL be latched with id_valid=1, pc SHALL hold, and the state SHALL become HALT the next cycle; a flushed or stalled halt word SHALL have no effect.
REQ-023 pc+1 SHALL wrap modulo 2^PC_WIDE (max value -> 0); branch_pc SHALL be taken unmodified.
REQ-024 fetch_count SHALL saturate at 16'hFFFF.
REQ-025 Fetch latency SHALL be one cycle: word at address A appears on id_instr the cycle after pc==A with a normal fetch.
REQ-026 halted SHALL be a registered decode of state HALT.

Reset
REQ-027 rst=0 SHALL immediately, independent of clk, force state=IDLE, pc=0, id_instr=0, id_pc_next=0, id_valid=0, halted=0, fetch_count=0.
REQ-028 Reset asserted mid-fetch or mid-flush SHALL discard all in-flight state; after release the block SHALL wait in IDLE for start.

Structure
REQ-029 FSM state encoding, HALT_OP and the NOP value (32'h0) SHALL live in a shared pipeline package, also used by branch_sum-side opcodes (BEQ, BNE, JUMP).
REQ-030 SHALL be a single module with no sub-modules; the PC register and IF/ID register SHALL reside in it.

Verification
REQ-031 Reset, start=1, imem returns addr-tagged words 32'h1000_0000+addr -> pc 0,1,2,3; id_instr 32'h1000_0000, 32'h1000_0001 in consecutive cycles; fetch_count 1,2.
REQ-032 stall=1 for 2 cycles at pc=5 -> pc stays 5, id_instr/id_valid frozen, fetch_count frozen; resumes at 5 then 6.
REQ-033 taken=1, branch_pc=7'd40 at pc=9 -> next cycle pc=40, id_valid=0, id_instr=0; following cycle id_instr=word 40, id_pc_next=41.
REQ-034 taken=1 and stall=1 together -> redirect ignored, full hold; taken alone next cycle -> redirect applied.
REQ-035 pc=7'd127 normal fetch -> id_pc_next=0, pc=0; halt word (opcode 6'b111111) at addr 3 -> id_instr=halt word, halted=1 next cycle, pc held at 3, start ignored.
REQ-036 rst pulsed low between edges while pc=20 in RUN -> all outputs 0 immediately, state IDLE, no fetch until start.
